// File: rtl/stage2_execute_pkg.sv
// Shared RV32I decode constants and the register-write predicate used by the
// execute stage and by the stage-1/stage-3 hazard logic.
package stage2_execute_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_SH      = 3'b001;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;
  localparam logic [2:0] F3_CSRRW   = 3'b001;
  localparam logic [2:0] F3_CSRRWI  = 3'b101;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [11:0] CSR_TOHOST = 12'h51E;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_ZERO
  } alu_op_t;

  function automatic logic writes_rd(input logic [31:0] inst);
    case (inst[6:0])
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:                      writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage2_execute_if.sv
// Data-cache request bus driven by the execute stage.
interface stage2_execute_if;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_din;
  logic [3:0]  dcache_we;
  logic        dcache_re;

  modport master (output dcache_addr, output dcache_din, output dcache_we, output dcache_re);
  modport slave  (input  dcache_addr, input  dcache_din, input  dcache_we, input  dcache_re);
endinterface

// File: rtl/stage2_execute_alu.sv
// Combinational RV32I ALU: one operation select, two operands, one result.
module stage2_alu
  import stage2_execute_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << b[4:0];
      ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {31'd0, a < b};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> b[4:0];
      ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = 32'd0;
    endcase
  end

endmodule

// File: rtl/stage2_execute.sv
// Execute stage of the 3-stage RV32I pipeline: operand registers, writeback
// forwarding, ALU, branch compare, data-cache request and the tohost CSR.
module stage2_execute
  import stage2_execute_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] stage1_inst,
  input  logic [31:0] stage1_pc,
  input  logic [31:0] stage1_imm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] stage3_inst,
  input  logic [31:0] wb_data,
  output logic [31:0] stage2_inst,
  output logic [31:0] stage2_pc,
  output logic [31:0] stage2_alu_out,
  output logic        BrEq,
  output logic        BrLT,
  output logic [31:0] csr_tohost,
  stage2_execute_if.master dcache
);

  logic [31:0] inst_q, pc_q, imm_q, rs1_q, rs2_q;
  logic [31:0] fwd_rs1, fwd_rs2, alu_a, alu_b, alu_out, store_din;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd3;
  logic [3:0]  store_we;
  logic [1:0]  off;
  logic        fwd_ok, alt, br_unsigned, csr_hit, unused_rd_bits;
  alu_op_t     alu_op;

  assign opcode         = inst_q[6:0];
  assign funct3         = inst_q[14:12];
  assign funct7         = inst_q[31:25];
  assign alt            = (funct7 == F7_ALT);
  assign unused_rd_bits = ^inst_q[11:7];

  // The writeback result overrides a stale operand register; x0 is never bypassed.
  always_comb begin
    rd3     = stage3_inst[11:7];
    fwd_ok  = writes_rd(stage3_inst) && (rd3 != 5'd0);
    fwd_rs1 = (fwd_ok && (rd3 == inst_q[19:15])) ? wb_data : rs1_q;
    fwd_rs2 = (fwd_ok && (rd3 == inst_q[24:20])) ? wb_data : rs2_q;
  end

  always_comb begin
    alu_op = ALU_ZERO;
    alu_a  = fwd_rs1;
    alu_b  = imm_q;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        if (opcode == OPC_OP) alu_b = fwd_rs2;
        case (funct3)
          F3_ADD_SUB: alu_op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
          F3_SLL:     alu_op = ALU_SLL;
          F3_SLT:     alu_op = ALU_SLT;
          F3_SLTU:    alu_op = ALU_SLTU;
          F3_XOR:     alu_op = ALU_XOR;
          F3_SR:      alu_op = alt ? ALU_SRA : ALU_SRL;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default:    alu_op = ALU_ZERO;
        endcase
      end
      OPC_LUI:                        alu_op = ALU_PASS_B;
      OPC_AUIPC, OPC_BRANCH, OPC_JAL: begin alu_op = ALU_ADD; alu_a = pc_q; end
      OPC_JALR, OPC_LOAD, OPC_STORE:  alu_op = ALU_ADD;
      default:                        alu_op = ALU_ZERO;
    endcase
  end

  stage2_alu u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .result(alu_out));

  assign br_unsigned = (opcode == OPC_BRANCH) && ((funct3 == F3_BLTU) || (funct3 == F3_BGEU));
  assign BrEq        = (fwd_rs1 == fwd_rs2);
  assign BrLT        = br_unsigned ? (fwd_rs1 < fwd_rs2) : ($signed(fwd_rs1) < $signed(fwd_rs2));

  // Misaligned halfword/word stores are dropped by leaving every byte enable low.
  always_comb begin
    off       = alu_out[1:0];
    store_we  = 4'b0000;
    store_din = fwd_rs2;
    if (opcode == OPC_STORE) begin
      case (funct3)
        F3_SB: begin
          store_we  = 4'b0001 << off;
          store_din = {4{fwd_rs2[7:0]}};
        end
        F3_SH: begin
          store_din = {2{fwd_rs2[15:0]}};
          if (!off[0]) store_we = 4'b0011 << off;
        end
        F3_SW:   if (off == 2'b00) store_we = 4'b1111;
        default: store_we = 4'b0000;
      endcase
    end
  end

  assign stage2_inst        = inst_q;
  assign stage2_pc          = pc_q;
  assign stage2_alu_out     = alu_out;
  assign dcache.dcache_addr = {alu_out[31:2], 2'b00};
  assign dcache.dcache_din  = store_din;
  assign dcache.dcache_we   = store_we;
  assign dcache.dcache_re   = (opcode == OPC_LOAD);

  assign csr_hit = (opcode == OPC_SYSTEM) && (inst_q[31:20] == CSR_TOHOST);

  // The CSR write happens as the instruction leaves stage 2, so a stall defers it.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q     <= NOP_INST;
      pc_q       <= RESET_PC;
      imm_q      <= 32'd0;
      rs1_q      <= 32'd0;
      rs2_q      <= 32'd0;
      csr_tohost <= 32'd0;
    end else if (!stall) begin
      inst_q <= stage1_inst;
      pc_q   <= stage1_pc;
      imm_q  <= stage1_imm;
      rs1_q  <= rs1_data;
      rs2_q  <= rs2_data;
      if (csr_hit && funct3 == F3_CSRRW)       csr_tohost <= fwd_rs1;
      else if (csr_hit && funct3 == F3_CSRRWI) csr_tohost <= {27'd0, inst_q[19:15]};
    end
  end

endmodule
